// File: rtl/bus_break_ser.sv
// rtl/bus_break_ser.sv - breaks an IN_W-bit word into SLICE_W-bit slices and streams them out
//
// Purpose:
//   Accepts one word per valid/ready handshake. It then emits the word as
//   NUM_SLICES slices, one per out_valid/out_ready transfer. The slice order
//   comes from msb_first, which is latched together with the word. A new word
//   can be accepted in the same cycle as the last slice of the current word,
//   so back-to-back words stream out without a bubble.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data / msb_first are valid
//   in_ready   out  word accepted this cycle when in_valid is high
//   in_data    in   IN_W-bit word
//   msb_first  in   1 = most-significant slice first, 0 = least-significant first
//   out_valid  out  out_data holds a slice
//   out_ready  in   downstream accepts the slice
//   out_data   out  SLICE_W-bit slice
//   out_idx    out  slice position in emission order, 0..NUM_SLICES-1
//   out_last   out  final slice of the word
//   out_parity out  XOR of out_data; present only with BUS_BREAK_PARITY_EN
//
// Build option:
//   BUS_BREAK_PARITY_EN - adds the out_parity output.

module bus_break_ser #(
  parameter  int IN_W       = 16,
  parameter  int SLICE_W    = 4,
  localparam int NUM_SLICES = IN_W / SLICE_W,
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic               msb_first,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last
`ifdef BUS_BREAK_PARITY_EN
  ,
  output logic               out_parity
`endif
);

  generate
    if ((SLICE_W < 1) || (SLICE_W > IN_W) || ((IN_W % SLICE_W) != 0)) begin : g_bad_params
      $error("bus_break_ser: IN_W must be a positive multiple of SLICE_W");
    end
  endgenerate

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e             state_q, state_d;
  logic [IN_W-1:0]    word_q, word_d;
  logic               msb_q, msb_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  // Held low through reset and for the first edge after release, so that
  // in_ready only rises on the first clock edge after rst_n deasserts.
  logic               rdy_q;

  logic               is_last;
  logic               accept;
  logic               xfer;
  logic [IDX_W-1:0]   sel;
  logic [IN_W-1:0]    shifted;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      msb_q   <= 1'b0;
      idx_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      msb_q   <= msb_d;
      idx_q   <= idx_d;
      rdy_q   <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    msb_d   = msb_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SEND;
      end
      S_SEND: begin
        // A last-slice transfer with a simultaneous accept stays in SEND.
        if (xfer && is_last && !accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      word_d = in_data;
      msb_d  = msb_first;
      idx_d  = '0;
    end else if (xfer) begin
      idx_d = is_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Outputs and handshake decode
  always_comb begin
    is_last   = (idx_q == LAST_IDX);
    out_valid = (state_q == S_SEND);
    out_last  = out_valid && is_last;
    out_idx   = idx_q;
    in_ready  = (state_q == S_IDLE) ? rdy_q : (is_last && out_ready);
    accept    = in_valid && in_ready;
    xfer      = out_valid && out_ready;
    // Emission position to physical slice number.
    sel       = msb_q ? (LAST_IDX - idx_q) : idx_q;
    shifted   = word_q >> (sel * SLICE_W);
    out_data  = out_valid ? shifted[SLICE_W-1:0] : '0;
  end

`ifdef BUS_BREAK_PARITY_EN
  // out_data is already forced to zero outside SEND, so parity is zero there too.
  always_comb begin
    out_parity = ^out_data;
  end
`endif

endmodule

// File: tb/tb_bus_break_ser.sv
// tb/tb_bus_break_ser.sv - directed table-driven bench for bus_break_ser

module tb_bus_break_ser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        msb_first = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_last;
  logic [3:0]  out_data;
  logic [1:0]  out_idx;

  logic        s_in_ready, s_out_valid, s_out_last;
  logic [3:0]  s_out_data;
  logic [0:0]  s_out_idx;

`ifdef BUS_BREAK_PARITY_EN
  logic        out_parity, s_out_parity;
`endif

  always #5 clk = ~clk;

  bus_break_ser #(.IN_W(16), .SLICE_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .msb_first(msb_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
`ifdef BUS_BREAK_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  // Single-slice configuration
  bus_break_ser #(.IN_W(4), .SLICE_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data[3:0]), .msb_first(msb_first),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_idx(s_out_idx), .out_last(s_out_last)
`ifdef BUS_BREAK_PARITY_EN
    , .out_parity(s_out_parity)
`endif
  );

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        msb;
    logic        ordy;
    logic        ev;
    logic [3:0]  ed;
    logic [1:0]  ei;
    logic        el;
    logic        er;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic iv, logic [15:0] d, logic msb, logic ordy,
                              logic ev, logic [3:0] ed, logic [1:0] ei, logic el, logic er);
    vec_t v;
    v.iv = iv; v.d = d; v.msb = msb; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.ei = ei; v.el = el; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic ev, input logic [3:0] ed,
                          input logic [1:0] ei, input logic el, input logic er);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".out_data"},  32'(out_data),  32'(ed));
    chk({tag, ".out_idx"},   32'(out_idx),   32'(ei));
    chk({tag, ".out_last"},  32'(out_last),  32'(el));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(er));
`ifdef BUS_BREAK_PARITY_EN
    chk({tag, ".out_parity"}, 32'(out_parity), 32'((^ed) & ev));
`endif
  endtask

  task automatic chk_s(input string tag, input logic ev, input logic [3:0] ed,
                       input logic el, input logic er);
    chk({tag, ".s_out_valid"}, 32'(s_out_valid), 32'(ev));
    chk({tag, ".s_out_data"},  32'(s_out_data),  32'(ed));
    chk({tag, ".s_out_idx"},   32'(s_out_idx),   32'(0));
    chk({tag, ".s_out_last"},  32'(s_out_last),  32'(el));
    chk({tag, ".s_in_ready"},  32'(s_in_ready),  32'(er));
  endtask

  initial begin
    logic [3:0] exp_0f0f [4];
    exp_0f0f = '{4'hF, 4'h0, 4'hF, 4'h0};

    //          iv  data      msb ordy  ev  ed    ei  el  er
    // A5C3 lsb-first
    vecs.push_back(mk(1, 16'hA5C3, 0, 1,  0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'h3, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'hC, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'h5, 2, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'hA, 3, 1, 1));
    // A5C3 msb-first
    vecs.push_back(mk(1, 16'hA5C3, 1, 1,  0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'hA, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'h5, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'hC, 2, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'h3, 3, 1, 1));
    // 1234 lsb-first, stall 3 cycles at idx 2 with junk on the input side
    vecs.push_back(mk(1, 16'h1234, 0, 1,  0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'h4, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'h3, 1, 0, 0));
    vecs.push_back(mk(1, 16'hFFFF, 1, 0,  1, 4'h2, 2, 0, 0));
    vecs.push_back(mk(1, 16'hFFFF, 1, 0,  1, 4'h2, 2, 0, 0));
    vecs.push_back(mk(1, 16'hFFFF, 1, 0,  1, 4'h2, 2, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'h2, 2, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0,  1, 4'h1, 3, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'h1, 3, 1, 1));
    // 1111 then 2222 back-to-back
    vecs.push_back(mk(1, 16'h1111, 0, 1,  0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(1, 16'h2222, 0, 1,  1, 4'h1, 0, 0, 0));
    vecs.push_back(mk(1, 16'h2222, 0, 1,  1, 4'h1, 1, 0, 0));
    vecs.push_back(mk(1, 16'h2222, 0, 1,  1, 4'h1, 2, 0, 0));
    vecs.push_back(mk(1, 16'h2222, 0, 1,  1, 4'h1, 3, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'h2, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'h2, 2, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  1, 4'h2, 3, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 1,  0, 4'h0, 0, 0, 1));

    // Reset state
    repeat (2) @(negedge clk);
    #1 chk_main("reset", 0, 4'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release.in_ready", 32'(in_ready), 32'(0));

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      msb_first = vecs[i].msb;
      out_ready = vecs[i].ordy;
      #1 chk_main($sformatf("row%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ei, vecs[i].el, vecs[i].er);
    end

    // Reset in the middle of BEEF, then a fresh word
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hBEEF; msb_first = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk_main("beef0", 1, 4'hF, 0, 0, 0);
    @(negedge clk);
    #1 chk_main("beef1", 1, 4'hE, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_main("rst_mid", 0, 4'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_rel.in_ready", 32'(in_ready), 32'(0));
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0F0F; msb_first = 1'b0;
    #1 chk_main("post_rst_idle", 0, 4'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk_main($sformatf("w0f0f_%0d", i), 1, exp_0f0f[i], 2'(i), i == 3, i == 3);
    end
    @(negedge clk);
    #1 chk_main("w0f0f_idle", 0, 4'h0, 0, 0, 1);

    // Single-slice instance
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0007; out_ready = 1'b1;
    #1 chk_s("s_idle", 0, 4'h0, 0, 1);
    @(negedge clk);
    in_data = 16'h0009;
    #1 chk_s("s_w7", 1, 4'h7, 1, 1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk_s("s_w9_stall", 1, 4'h9, 1, 0);
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk_s("s_w9_go", 1, 4'h9, 1, 1);
    @(negedge clk);
    #1 chk_s("s_done", 0, 4'h0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
